// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Purpose:
//   Classifies activations of a debounced, clock-synchronous button level into
//   press/release edges, short press, double press and long press with
//   auto-repeat while the button stays held. All event outputs are registered
//   single-cycle pulses. held_o is a registered level.
//
// Parameters:
//   CNT_W         width of the shared interval counter
//   LONG_CYCLES   hold time (cycles) that qualifies a long press
//   REPEAT_CYCLES auto-repeat period (cycles) after a long press
//   DOUBLE_CYCLES window (cycles) after a release for a second press
//   Every *_CYCLES value must be >= 2 and <= 2**CNT_W - 1.
//
// Ports:
//   clk_i           system clock, all logic on the rising edge
//   rst_ni          asynchronous active-low reset (deassertion synchronised)
//   level_i         debounced button level, 1 = pressed, synchronous to clk_i
//   press_o         pulse on each accepted press
//   release_o       pulse on each release
//   short_press_o   pulse when a single short activation is confirmed
//   double_press_o  pulse when a second short press completes in the window
//   long_press_o    pulse when a hold reaches LONG_CYCLES
//   repeat_tick_o   pulse every REPEAT_CYCLES while held after a long press
//   held_o          high while the decoder is in a pressed state
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = 12_000_000,
    parameter int REPEAT_CYCLES = 3_000_000,
    parameter int DOUBLE_CYCLES = 6_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic press_o,
    output logic release_o,
    output logic short_press_o,
    output logic double_press_o,
    output logic long_press_o,
    output logic repeat_tick_o,
    output logic held_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    // The counter is cleared on entry to a state, so after N cycles in the
    // state it reads N-1 at the deciding edge; compare against N-1 so the
    // registered pulse appears exactly N cycles after entry.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Reset release synchroniser: assertion is immediate, release takes two
    // clock edges before the decoder starts sampling.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    // State and registered outputs
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             tick_q, tick_d;
    logic             held_q, held_d;

    logic rise;
    logic fall;

    assign rise = level_i & ~prev_q;
    assign fall = ~level_i & prev_q;

    // Next-state and output decode. In every state an edge is tested before
    // the threshold, so an edge always wins a same-cycle tie.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        prev_d    = level_i;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        tick_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No threshold in IDLE: park the counter so it cannot wrap.
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESS1;
                    press_d = 1'b1;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d   = ST_WAIT2;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    press_d = 1'b1;
                end else if (cnt_q == DOUBLE_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    double_d  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    // Stay in LONG; restarting the count gives the period.
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        held_d = (state_d == ST_PRESS1) || (state_d == ST_PRESS2) ||
                 (state_d == ST_LONG);

        // Until the synchronised reset release arrives, hold everything at
        // its reset value; prev stays 0 so a button already held is seen as
        // a rise on the first active edge.
        if (!run) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            prev_d    = 1'b0;
            press_d   = 1'b0;
            release_d = 1'b0;
            short_d   = 1'b0;
            double_d  = 1'b0;
            long_d    = 1'b0;
            tick_d    = 1'b0;
            held_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            tick_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            double_q  <= double_d;
            long_q    <= long_d;
            tick_q    <= tick_d;
            held_q    <= held_d;
        end
    end

    assign press_o        = press_q;
    assign release_o      = release_q;
    assign short_press_o  = short_q;
    assign double_press_o = double_q;
    assign long_press_o   = long_q;
    assign repeat_tick_o  = tick_q;
    assign held_o         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Builds a level waveform from directed and random high/low segments, derives
// the expected pulse train from interval arithmetic on that waveform, then
// plays the waveform into the decoder and compares every output every cycle.
// Finishes with a reset-during-long-press scenario.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

    localparam int CNT_W  = 8;
    localparam int LONG_C = 20;
    localparam int REP_C  = 8;
    localparam int DBL_C  = 10;
    localparam int MAXC   = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic level = 1'b0;
    logic press, rel, short_p, dbl, long_p, tick, held;

    always #5 clk = ~clk;

    button_event_decoder #(
        .CNT_W        (CNT_W),
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .DOUBLE_CYCLES(DBL_C)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .level_i       (level),
        .press_o       (press),
        .release_o     (rel),
        .short_press_o (short_p),
        .double_press_o(dbl),
        .long_press_o  (long_p),
        .repeat_tick_o (tick),
        .held_o        (held)
    );

    int tests = 0;
    int fails = 0;

    // Stimulus waveform: lv[c] is the level sampled at active edge c.
    bit lv [MAXC];
    int n = 0;

    // Expected outputs as seen just after edge c.
    bit e_press [MAXC];
    bit e_rel   [MAXC];
    bit e_short [MAXC];
    bit e_dbl   [MAXC];
    bit e_long  [MAXC];
    bit e_tick  [MAXC];
    bit e_held  [MAXC];

    // Logged DUT outputs, used for the directed timing checks.
    logic o_press [MAXC];
    logic o_rel   [MAXC];
    logic o_short [MAXC];
    logic o_dbl   [MAXC];
    logic o_long  [MAXC];
    logic o_tick  [MAXC];

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic add_seg(input bit val, input int len);
        for (int i = 0; i < len; i++) begin
            lv[n] = val;
            n++;
        end
    endtask

    function automatic int next_rise(input int from);
        for (int i = from; i < n; i++) begin
            if (lv[i] && (i == 0 || !lv[i-1])) return i;
        end
        return n;
    endfunction

    function automatic int next_fall(input int from);
        for (int i = from; i < n; i++) begin
            if (!lv[i]) return i;
        end
        return n;
    endfunction

    task automatic mark_held(input int a, input int b);
        for (int i = a; i < b && i < MAXC; i++) e_held[i] = 1'b1;
    endtask

    // Long hold from press t to release edge f (f - t > LONG_C).
    task automatic long_path(input int t, input int f);
        e_long[t + LONG_C] = 1'b1;
        for (int k = t + LONG_C + REP_C; k < f; k += REP_C) e_tick[k] = 1'b1;
        if (f < MAXC) e_rel[f] = 1'b1;
        mark_held(t, f);
    endtask

    // Walk the waveform activation by activation using hold/gap durations.
    task automatic build_model();
        int c, t, f, r, t2, f2;
        c = next_rise(0);
        while (c < n) begin
            t = c;
            e_press[t] = 1'b1;
            f = next_fall(t + 1);
            if (f - t <= LONG_C) begin
                e_rel[f] = 1'b1;
                mark_held(t, f);
                r  = f;
                t2 = next_rise(r + 1);
                if (t2 - r <= DBL_C) begin
                    e_press[t2] = 1'b1;
                    f2 = next_fall(t2 + 1);
                    if (f2 - t2 <= LONG_C) begin
                        e_dbl[f2] = 1'b1;
                        e_rel[f2] = 1'b1;
                        mark_held(t2, f2);
                    end else begin
                        long_path(t2, f2);
                    end
                    c = next_rise(f2 + 1);
                end else begin
                    e_short[r + DBL_C] = 1'b1;
                    c = t2;
                end
            end else begin
                long_path(t, f);
                c = next_rise(f + 1);
            end
        end
    endtask

    initial begin
        int s1, s2, s3, s4, s5, s6, s7, r, k, hi, lo;
        bit found;

        // ---------------- waveform construction ----------------
        add_seg(1'b0, 2);
        s1 = n; add_seg(1'b1, 5);  add_seg(1'b0, 20);
        s2 = n; add_seg(1'b1, 3);  add_seg(1'b0, 4);  add_seg(1'b1, 3); add_seg(1'b0, 20);
        s3 = n; add_seg(1'b1, 40); add_seg(1'b0, 20);
        s4 = n; add_seg(1'b1, 20); add_seg(1'b0, 20);
        s5 = n; add_seg(1'b1, 21); add_seg(1'b0, 20);
        s6 = n; add_seg(1'b1, 3);  add_seg(1'b0, 10); add_seg(1'b1, 3); add_seg(1'b0, 20);
        s7 = n; add_seg(1'b1, 3);  add_seg(1'b0, 11); add_seg(1'b1, 3); add_seg(1'b0, 20);
        for (int i = 0; i < 40; i++) begin
            hi = int'($urandom_range(1, 45));
            lo = int'($urandom_range(1, 16));
            $display("[TB] random segment %0d at cycle %0d: high %0d, low %0d", i, n, hi, lo);
            add_seg(1'b1, hi);
            add_seg(1'b0, lo);
        end
        add_seg(1'b0, 30);
        build_model();

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        level = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_press", press, 1'b0);
        check("reset_release", rel, 1'b0);
        check("reset_short", short_p, 1'b0);
        check("reset_double", dbl, 1'b0);
        check("reset_long", long_p, 1'b0);
        check("reset_tick", tick, 1'b0);
        check("reset_held", held, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // ---------------- main waveform, cycle by cycle ----------------
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            level = lv[c];
            @(posedge clk);
            #1;
            o_press[c] = press;
            o_rel[c]   = rel;
            o_short[c] = short_p;
            o_dbl[c]   = dbl;
            o_long[c]  = long_p;
            o_tick[c]  = tick;
            check($sformatf("press@%0d", c), press, e_press[c]);
            check($sformatf("release@%0d", c), rel, e_rel[c]);
            check($sformatf("short@%0d", c), short_p, e_short[c]);
            check($sformatf("double@%0d", c), dbl, e_dbl[c]);
            check($sformatf("long@%0d", c), long_p, e_long[c]);
            check($sformatf("tick@%0d", c), tick, e_tick[c]);
            check($sformatf("held@%0d", c), held, e_held[c]);
        end
        $display("[TB] main waveform of %0d cycles applied", n);

        // ---------------- directed timing points ----------------
        check("short_rel_t5", o_rel[s1 + 5], 1'b1);
        check("short_pulse_t15", o_short[s1 + 15], 1'b1);
        check("dbl_press2_t7", o_press[s2 + 7], 1'b1);
        check("dbl_pulse_t10", o_dbl[s2 + 10], 1'b1);
        check("dbl_rel_t10", o_rel[s2 + 10], 1'b1);
        check("long_t20", o_long[s3 + 20], 1'b1);
        check("tick_t28", o_tick[s3 + 28], 1'b1);
        check("tick_t36", o_tick[s3 + 36], 1'b1);
        check("long_rel_t40", o_rel[s3 + 40], 1'b1);
        check("hold20_no_long", o_long[s4 + 20], 1'b0);
        check("hold20_rel", o_rel[s4 + 20], 1'b1);
        check("hold20_short_t30", o_short[s4 + 30], 1'b1);
        check("hold21_long_t20", o_long[s5 + 20], 1'b1);
        check("hold21_rel_t21", o_rel[s5 + 21], 1'b1);
        r = s6 + 3;
        check("win_edge_press_r10", o_press[r + 10], 1'b1);
        check("win_edge_no_short", o_short[r + 10], 1'b0);
        check("win_edge_double", o_dbl[r + 13], 1'b1);
        r = s7 + 3;
        check("win_late_short_r10", o_short[r + 10], 1'b1);
        check("win_late_press_r11", o_press[r + 11], 1'b1);
        check("win_late_no_double", o_dbl[r + 14], 1'b0);

        // ---------------- reset during LONG ----------------
        @(negedge clk);
        level = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 5) begin
            @(posedge clk);
            #1;
            k++;
            if (press === 1'b1) found = 1'b1;
        end
        check("rt_first_press", found, 1'b1);
        repeat (25) @(posedge clk);
        #1;
        check("rt_held_in_long", held, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rt_async_press", press, 1'b0);
        check("rt_async_release", rel, 1'b0);
        check("rt_async_short", short_p, 1'b0);
        check("rt_async_double", dbl, 1'b0);
        check("rt_async_long", long_p, 1'b0);
        check("rt_async_tick", tick, 1'b0);
        check("rt_async_held", held, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rt_in_reset_held%0d", i), held, 1'b0);
            check($sformatf("rt_in_reset_release%0d", i), rel, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released with level held high");
        k = 0;
        found = 1'b0;
        while (!found && k < 8) begin
            @(posedge clk);
            #1;
            k++;
            if (press === 1'b1) found = 1'b1;
        end
        check("rt_press_after_reset", found, 1'b1);
        check("rt_held_after_press", held, 1'b1);
        for (int j = 1; j <= LONG_C; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("rt_long_at_press+%0d", j), long_p, (j == LONG_C) ? 1'b1 : 1'b0);
        end
        check("rt_held_at_long", held, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Downstream consumer of the button debouncer. Takes the debounced, clock-synchronous button level and classifies each activation as press/release edges, short press, double press, or long press with auto-repeat while held. All outputs are registered single-cycle pulses except `held`, ready for direct use by the UI/menu logic.

## Interface

- `CNT_W`, 24: width of the shared interval counter.
- `LONG_CYCLES`, 12_000_000: hold time (cycles) that qualifies a long press.
- `REPEAT_CYCLES`, 3_000_000: auto-repeat period (cycles) after a long press.
- `DOUBLE_CYCLES`, 6_000_000: window (cycles) after a release in which a second press makes a double press.
- Parameter constraint: each `*_CYCLES` value is ≥2 and ≤2^CNT_W−1.

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `level`  in  1  debounced button level from the debouncer, 1 = pressed, synchronous to `clk`.
- `press`  out  1  one-cycle pulse on each accepted press.
- `release`  out  1  one-cycle pulse on each release.
- `short_press`  out  1  one-cycle pulse: single short activation confirmed.
- `double_press`  out  1  one-cycle pulse: second short press completed inside the window.
- `long_press`  out  1  one-cycle pulse: hold reached `LONG_CYCLES`.
- `repeat_tick`  out  1  one-cycle pulse every `REPEAT_CYCLES` while held after a long press.
- `held`  out  1  high while the FSM is in a pressed state.

## Operation

- `prev` register holds the last sampled `level`. rise = level & ~prev, fall = ~level & prev.
- One counter `cnt` (CNT_W bits), cleared on every state transition and incremented every cycle otherwise. It never wraps, because every state exits or clears at its threshold.
- FSM states:
  - IDLE: on rise, go to PRESS1 and pulse `press`.
  - PRESS1: on fall, go to WAIT2 and pulse `release`. Otherwise, at threshold LONG, go to LONG and pulse `long_press`.
  - WAIT2: on rise, go to PRESS2 and pulse `press`. Otherwise, at threshold DOUBLE, go to IDLE and pulse `short_press`.
  - PRESS2: on fall, go to IDLE and pulse `double_press` + `release`. Otherwise, at threshold LONG, go to LONG and pulse `long_press` (no double).
  - LONG: on fall, go to IDLE and pulse `release` (no short). Otherwise, at threshold REPEAT, pulse `repeat_tick` and clear `cnt`.
- `held` = state ∈ {PRESS1, PRESS2, LONG}, registered.
- Simultaneous events: an edge always beats a threshold in the same cycle.
  - A fall at the LONG threshold is a release (short path); no `long_press`.
  - A rise at the DOUBLE threshold is accepted as the second press; no `short_press`.
  - A fall at the REPEAT threshold gives `release` only; no `repeat_tick`.
- At most one of `short_press`, `double_press`, `long_press` per activation.

## Timing

- Reset (async assert): state IDLE, `cnt`=0, `prev`=0, all outputs 0 immediately. Deassertion is synchronised internally.
- A button already held when reset releases is seen as a rise. `press` appears 1 cycle after the first sampling edge.
- Latency from `level` change to `press`/`release`: 1 cycle. `held` rises with `press` and falls with `release`.
- With `press` at cycle t and level held: `long_press` at t+LONG_CYCLES, then `repeat_tick` at t+LONG_CYCLES+k·REPEAT_CYCLES, k≥1.
- If `level` falls so that `release` would land at t+h:
  - h ≤ LONG_CYCLES: short path.
  - h > LONG_CYCLES: long path.
- With `release` at cycle r in WAIT2:
  - `short_press` at r+DOUBLE_CYCLES if no second press.
  - A second press is accepted if its `press` lands at ≤ r+DOUBLE_CYCLES.
- Reset mid-operation aborts the activation silently; no pending pulse is emitted.

## Test plan

Parameters: CNT_W=8, LONG_CYCLES=20, REPEAT_CYCLES=8, DOUBLE_CYCLES=10.

- Short press: level high 5 cycles, then low 20 -> `press` at t, `release` at t+5, `short_press` at t+15. No other pulses.
- Double press: high 3, low 4, high 3, low -> `press` at t and t+7, `release` at t+3, `double_press`+`release` at t+10. No `short_press`.
- Long + repeat: high 40 cycles -> `press` t, `long_press` t+20, `repeat_tick` t+28 and t+36, `release` t+40. No short/double.
- Boundaries:
  - High exactly 20 cycles -> `release` t+20, no `long_press`, `short_press` t+30.
  - High 21 cycles -> `long_press` t+20, `release` t+21.
- Window edge: second `press` lands exactly at r+10 -> no `short_press`, FSM in PRESS2, `double_press` on its release. Second `press` at r+11 -> `short_press` at r+10, then a fresh activation.
- Reset during LONG: pull `rst_n` low -> all outputs 0 and `held`=0 at once. Release reset with level still high -> `press` 1 cycle after the first edge, `long_press` 20 cycles later.
